// File: rtl/mips_pkg.sv
// Shared MIPS32 pipeline constants: ExcCodes, exception vector, control FSM states.
package mips_pkg;

  localparam int unsigned EXC_W  = 5;
  localparam int unsigned XLEN   = 32;

  localparam logic [EXC_W-1:0] EXC_NONE = 5'd0;
  localparam logic [EXC_W-1:0] EXC_ADEL = 5'd4;
  localparam logic [EXC_W-1:0] EXC_SYS  = 5'd8;
  localparam logic [EXC_W-1:0] EXC_BP   = 5'd9;
  localparam logic [EXC_W-1:0] EXC_RI   = 5'd10;
  localparam logic [EXC_W-1:0] EXC_OV   = 5'd12;

  localparam logic [XLEN-1:0] EXC_VECTOR = 32'hBFC0_0380;

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } state_e;

  // EPC points at the branch when the faulting instruction sits in a delay slot
  function automatic logic [XLEN-1:0] calc_epc(input logic [XLEN-1:0] pc, input logic bd);
    return bd ? (pc - XLEN'(4)) : pc;
  endfunction

endpackage

// File: rtl/exc_prio_enc.sv
// Maps MEM-stage exception flags to an ExcCode; the lowest flag bit wins.
module exc_prio_enc
  import mips_pkg::*;
(
  input  logic [EXC_W-1:0] exc_flags,
  output logic [EXC_W-1:0] exc_code_c
);

  // Fixed priority: fetch address error, syscall, break, reserved instr, overflow
  always_comb begin
    exc_code_c = EXC_NONE;
    if (exc_flags[0])      exc_code_c = EXC_ADEL;
    else if (exc_flags[1]) exc_code_c = EXC_SYS;
    else if (exc_flags[2]) exc_code_c = EXC_BP;
    else if (exc_flags[3]) exc_code_c = EXC_RI;
    else if (exc_flags[4]) exc_code_c = EXC_OV;
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Five-stage handshake, flush and precise-exception controller for the MIPS32 pipeline.
module pipe_ctrl
  import mips_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             IF_done,
  input  logic             ID_done,
  input  logic             EXE_done,
  input  logic             MEM_done,
  input  logic             WB_done,
  input  logic             ID_hazard,
  input  logic             IF_busy,
  input  logic [EXC_W-1:0] MEM_exc,
  input  logic             MEM_delay,
  input  logic [XLEN-1:0]  MEM_pc,
  output logic             IF_over,
  output logic             ID_over,
  output logic             EXE_over,
  output logic             MEM_over,
  output logic             WB_over,
  output logic             IF_allow_in,
  output logic             ID_allow_in,
  output logic             EXE_allow_in,
  output logic             MEM_allow_in,
  output logic             WB_allow_in,
  output logic             IF_valid,
  output logic             ID_valid,
  output logic             EXE_valid,
  output logic             MEM_valid,
  output logic             WB_valid,
  output logic             cancel,
  output logic             pc_redirect,
  output logic             fetch_en,
  output logic             drop_fetch,
  output logic [EXC_W-1:0] exc_cause,
  output logic             exc_bd,
  output logic [XLEN-1:0]  exc_epc
);

  logic if_valid_q,  if_valid_d;
  logic id_valid_q,  id_valid_d;
  logic exe_valid_q, exe_valid_d;
  logic mem_valid_q, mem_valid_d;
  logic wb_valid_q,  wb_valid_d;
  state_e state_q, state_d;
  logic [EXC_W-1:0] exc_cause_q, exc_cause_d;
  logic             exc_bd_q,    exc_bd_d;
  logic [XLEN-1:0]  exc_epc_q,   exc_epc_d;
  logic [EXC_W-1:0] exc_code_c;
  logic             take_exc_c;

  exc_prio_enc u_exc_prio_enc (
    .exc_flags  (MEM_exc),
    .exc_code_c (exc_code_c)
  );

  assign IF_valid  = if_valid_q;
  assign ID_valid  = id_valid_q;
  assign EXE_valid = exe_valid_q;
  assign MEM_valid = mem_valid_q;
  assign WB_valid  = wb_valid_q;
  assign exc_cause = exc_cause_q;
  assign exc_bd    = exc_bd_q;
  assign exc_epc   = exc_epc_q;

  // Exception acceptance, stage over flags and back-pressure chain from WB towards IF
  always_comb begin
    take_exc_c   = ~reset & mem_valid_q & (|MEM_exc) & (state_q == RUN);
    cancel       = take_exc_c;
    pc_redirect  = take_exc_c;
    IF_over      = if_valid_q & IF_done;
    ID_over      = id_valid_q & ID_done & ~ID_hazard;
    EXE_over     = exe_valid_q & EXE_done;
    MEM_over     = mem_valid_q & MEM_done & ~take_exc_c;
    WB_over      = wb_valid_q & WB_done;
    WB_allow_in  = ~wb_valid_q | WB_done;
    MEM_allow_in = ~mem_valid_q | (MEM_over & WB_allow_in);
    EXE_allow_in = ~exe_valid_q | (EXE_over & MEM_allow_in);
    ID_allow_in  = ~id_valid_q | (ID_over & EXE_allow_in);
    IF_allow_in  = ~if_valid_q | (IF_over & ID_allow_in);
  end

  // Refetch FSM: while a squashed fetch is still on the bus, block new fetches and drop its data
  always_comb begin
    state_d    = state_q;
    fetch_en   = 1'b0;
    drop_fetch = 1'b0;
    case (state_q)
      RUN: begin
        fetch_en = 1'b1;
        if (take_exc_c && IF_busy) state_d = DRAIN;
      end
      DRAIN: begin
        drop_fetch = 1'b1;
        if (!IF_busy) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  // Valid bits advance on allow_in; an exception squashes IF..MEM while WB retires normally
  always_comb begin
    if_valid_d  = IF_allow_in  ? fetch_en : if_valid_q;
    id_valid_d  = ID_allow_in  ? IF_over  : id_valid_q;
    exe_valid_d = EXE_allow_in ? ID_over  : exe_valid_q;
    mem_valid_d = MEM_allow_in ? EXE_over : mem_valid_q;
    wb_valid_d  = WB_allow_in  ? MEM_over : wb_valid_q;
    if (take_exc_c) begin
      if_valid_d  = 1'b0;
      id_valid_d  = 1'b0;
      exe_valid_d = 1'b0;
      mem_valid_d = 1'b0;
    end
  end

  // CP0 exception record, held until the next accepted exception
  always_comb begin
    exc_cause_d = exc_cause_q;
    exc_bd_d    = exc_bd_q;
    exc_epc_d   = exc_epc_q;
    if (take_exc_c) begin
      exc_cause_d = exc_code_c;
      exc_bd_d    = MEM_delay;
      exc_epc_d   = calc_epc(MEM_pc, MEM_delay);
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      if_valid_q  <= 1'b0;
      id_valid_q  <= 1'b0;
      exe_valid_q <= 1'b0;
      mem_valid_q <= 1'b0;
      wb_valid_q  <= 1'b0;
      state_q     <= RUN;
      exc_cause_q <= EXC_NONE;
      exc_bd_q    <= 1'b0;
      exc_epc_q   <= '0;
    end else begin
      if_valid_q  <= if_valid_d;
      id_valid_q  <= id_valid_d;
      exe_valid_q <= exe_valid_d;
      mem_valid_q <= mem_valid_d;
      wb_valid_q  <= wb_valid_d;
      state_q     <= state_d;
      exc_cause_q <= exc_cause_d;
      exc_bd_q    <= exc_bd_d;
      exc_epc_q   <= exc_epc_d;
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed, table-driven bench for pipe_ctrl.
module tb_pipe_ctrl;

  logic        clk;
  logic        reset;
  logic [4:0]  dn;          // {IF,ID,EXE,MEM,WB} done
  logic        hz;
  logic        busy;
  logic [4:0]  mem_exc;
  logic        mem_delay;
  logic [31:0] mem_pc;

  logic if_over, id_over, exe_over, mem_over, wb_over;
  logic if_allow, id_allow, exe_allow, mem_allow, wb_allow;
  logic if_valid, id_valid, exe_valid, mem_valid, wb_valid;
  logic cancel, pc_redirect, fetch_en, drop_fetch;
  logic [4:0]  exc_cause;
  logic        exc_bd;
  logic [31:0] exc_epc;

  logic [4:0] valid_v;
  logic [4:0] allow_v;
  assign valid_v = {if_valid, id_valid, exe_valid, mem_valid, wb_valid};
  assign allow_v = {if_allow, id_allow, exe_allow, mem_allow, wb_allow};

  int nchk = 0;
  int nerr = 0;

  pipe_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .IF_done      (dn[4]),
    .ID_done      (dn[3]),
    .EXE_done     (dn[2]),
    .MEM_done     (dn[1]),
    .WB_done      (dn[0]),
    .ID_hazard    (hz),
    .IF_busy      (busy),
    .MEM_exc      (mem_exc),
    .MEM_delay    (mem_delay),
    .MEM_pc       (mem_pc),
    .IF_over      (if_over),
    .ID_over      (id_over),
    .EXE_over     (exe_over),
    .MEM_over     (mem_over),
    .WB_over      (wb_over),
    .IF_allow_in  (if_allow),
    .ID_allow_in  (id_allow),
    .EXE_allow_in (exe_allow),
    .MEM_allow_in (mem_allow),
    .WB_allow_in  (wb_allow),
    .IF_valid     (if_valid),
    .ID_valid     (id_valid),
    .EXE_valid    (exe_valid),
    .MEM_valid    (mem_valid),
    .WB_valid     (wb_valid),
    .cancel       (cancel),
    .pc_redirect  (pc_redirect),
    .fetch_en     (fetch_en),
    .drop_fetch   (drop_fetch),
    .exc_cause    (exc_cause),
    .exc_bd       (exc_bd),
    .exc_epc      (exc_epc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Global time bound
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "watchdog");
  end

  typedef struct packed {
    logic [4:0] dn;
    logic       hz;
    logic [4:0] v;   // expected {IF,ID,EXE,MEM,WB} valid this cycle
    logic [4:0] a;   // expected allow_in, same order
  } vec_t;

  typedef struct packed {
    logic [4:0]  flags;
    logic [31:0] pc;
    logic        dly;
    logic [4:0]  cause;
    logic [31:0] epc;
  } exc_vec_t;

  vec_t     vecs  [15];
  exc_vec_t evecs [3];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h required 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Run with everything done until an instruction sits in MEM
  task automatic fill_pipe();
    int k;
    k = 0;
    dn = 5'b11111; hz = 1'b0; busy = 1'b0; mem_exc = 5'b0;
    while (!mem_valid && k < 12) begin
      tick();
      k++;
    end
    chk("fill_mem_valid", 32'(mem_valid), 32'd1);
  endtask

  initial begin
    vecs[0]  = '{5'b11111, 1'b0, 5'b00000, 5'b11111};
    vecs[1]  = '{5'b11111, 1'b0, 5'b10000, 5'b11111};
    vecs[2]  = '{5'b11111, 1'b0, 5'b11000, 5'b11111};
    vecs[3]  = '{5'b11111, 1'b0, 5'b11100, 5'b11111};
    vecs[4]  = '{5'b11111, 1'b0, 5'b11110, 5'b11111};
    vecs[5]  = '{5'b11111, 1'b0, 5'b11111, 5'b11111};
    vecs[6]  = '{5'b11111, 1'b1, 5'b11111, 5'b00111};
    vecs[7]  = '{5'b11111, 1'b1, 5'b11011, 5'b00111};
    vecs[8]  = '{5'b11111, 1'b0, 5'b11001, 5'b11111};
    vecs[9]  = '{5'b11111, 1'b0, 5'b11100, 5'b11111};
    vecs[10] = '{5'b11111, 1'b0, 5'b11110, 5'b11111};
    vecs[11] = '{5'b11110, 1'b0, 5'b11111, 5'b00000};
    vecs[12] = '{5'b11110, 1'b0, 5'b11111, 5'b00000};
    vecs[13] = '{5'b11110, 1'b0, 5'b11111, 5'b00000};
    vecs[14] = '{5'b11111, 1'b0, 5'b11111, 5'b11111};

    evecs[0] = '{5'b11100, 32'h0000_0000, 1'b1, 5'd9,  32'hFFFF_FFFC};
    evecs[1] = '{5'b11000, 32'h1234_5678, 1'b0, 5'd10, 32'h1234_5678};
    evecs[2] = '{5'b10000, 32'h8000_1000, 1'b1, 5'd12, 32'h8000_0FFC};

    // Reset state
    reset = 1'b1; dn = 5'b0; hz = 1'b0; busy = 1'b0;
    mem_exc = 5'b11111; mem_delay = 1'b1; mem_pc = 32'h1234_0000;
    tick(); tick();
    @(negedge clk);
    chk("rst_valid", 32'(valid_v), 32'd0);
    chk("rst_cancel", 32'(cancel), 32'd0);
    chk("rst_pc_redirect", 32'(pc_redirect), 32'd0);
    chk("rst_fetch_en", 32'(fetch_en), 32'd1);
    chk("rst_drop_fetch", 32'(drop_fetch), 32'd0);
    chk("rst_exc_cause", 32'(exc_cause), 32'd0);
    chk("rst_exc_bd", 32'(exc_bd), 32'd0);
    chk("rst_exc_epc", exc_epc, 32'd0);
    tick();
    reset = 1'b0; mem_exc = 5'b0; mem_delay = 1'b0; mem_pc = 32'h0;

    // Fill, hazard stall, WB stall
    for (int i = 0; i < 15; i++) begin
      dn = vecs[i].dn;
      hz = vecs[i].hz;
      @(negedge clk);
      chk($sformatf("vec%0d_valid", i), 32'(valid_v), 32'(vecs[i].v));
      chk($sformatf("vec%0d_allow", i), 32'(allow_v), 32'(vecs[i].a));
      chk($sformatf("vec%0d_cancel", i), 32'(cancel), 32'd0);
      tick();
    end
    hz = 1'b0;

    // Syscall in delay slot, MEM and WB not done, no fetch in flight
    dn = 5'b11100; mem_exc = 5'b00010; mem_delay = 1'b1; mem_pc = 32'h8000_0010;
    @(negedge clk);
    chk("sys_cancel", 32'(cancel), 32'd1);
    chk("sys_pc_redirect", 32'(pc_redirect), 32'd1);
    chk("sys_mem_over", 32'(mem_over), 32'd0);
    chk("sys_allow", 32'(allow_v), 32'd0);
    tick();
    mem_exc = 5'b0; dn = 5'b11111;
    @(negedge clk);
    chk("sys_cancel_1cyc", 32'(cancel), 32'd0);
    chk("sys_valid_after", 32'(valid_v), 32'b00001);
    chk("sys_cause", 32'(exc_cause), 32'd8);
    chk("sys_bd", 32'(exc_bd), 32'd1);
    chk("sys_epc", exc_epc, 32'h8000_000C);
    chk("sys_fetch_en", 32'(fetch_en), 32'd1);
    tick();
    @(negedge clk);
    chk("sys_refetch", 32'(valid_v), 32'b10000);

    // AdEL + Ov with a fetch outstanding: drain for 4 cycles
    fill_pipe();
    mem_exc = 5'b10001; busy = 1'b1; mem_delay = 1'b0; mem_pc = 32'h0040_0004;
    @(negedge clk);
    chk("adel_cancel", 32'(cancel), 32'd1);
    tick();
    mem_exc = 5'b11111;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("drain%0d_drop", k), 32'(drop_fetch), 32'd1);
      chk($sformatf("drain%0d_fetch_en", k), 32'(fetch_en), 32'd0);
      chk($sformatf("drain%0d_cancel", k), 32'(cancel), 32'd0);
      chk($sformatf("drain%0d_cause", k), 32'(exc_cause), 32'd4);
      tick();
    end
    chk("adel_epc", exc_epc, 32'h0040_0004);
    chk("adel_bd", 32'(exc_bd), 32'd0);
    busy = 1'b0; mem_exc = 5'b0;
    tick();
    @(negedge clk);
    chk("drain_exit_fetch_en", 32'(fetch_en), 32'd1);
    chk("drain_exit_drop", 32'(drop_fetch), 32'd0);
    chk("drain_exit_valid", 32'(valid_v), 32'd0);
    tick();
    @(negedge clk);
    chk("drain_refetch", 32'(valid_v), 32'b10000);

    // Priority and EPC arithmetic
    for (int e = 0; e < 3; e++) begin
      fill_pipe();
      mem_exc = evecs[e].flags; mem_pc = evecs[e].pc; mem_delay = evecs[e].dly;
      @(negedge clk);
      chk($sformatf("exc%0d_cancel", e), 32'(cancel), 32'd1);
      tick();
      mem_exc = 5'b0;
      @(negedge clk);
      chk($sformatf("exc%0d_cause", e), 32'(exc_cause), 32'(evecs[e].cause));
      chk($sformatf("exc%0d_bd", e), 32'(exc_bd), 32'(evecs[e].dly));
      chk($sformatf("exc%0d_epc", e), exc_epc, evecs[e].epc);
      chk($sformatf("exc%0d_squash", e), 32'(valid_v[4:1]), 32'd0);
    end

    // Reset during DRAIN
    fill_pipe();
    mem_exc = 5'b00001; busy = 1'b1; mem_pc = 32'h0000_0100; mem_delay = 1'b0;
    tick();
    mem_exc = 5'b0;
    @(negedge clk);
    chk("rstd_in_drain", 32'(drop_fetch), 32'd1);
    tick();
    reset = 1'b1;
    @(negedge clk);
    chk("rstd_cancel", 32'(cancel), 32'd0);
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("rstd_fetch_en", 32'(fetch_en), 32'd1);
    chk("rstd_drop", 32'(drop_fetch), 32'd0);
    chk("rstd_valid", 32'(valid_v), 32'd0);
    chk("rstd_cause", 32'(exc_cause), 32'd0);
    chk("rstd_bd", 32'(exc_bd), 32'd0);
    chk("rstd_epc", exc_epc, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Central handshake and flush controller for the five-stage MIPS32 pipeline (IF, ID, EXE, MEM, WB). It tracks per-stage valid bits and generates the `*_over` / `*_allow_in` pairs and the global `cancel` that drive every inter-stage register. It also takes precise exceptions at MEM: it latches the MIPS cause code, branch-delay flag and EPC for CP0, and redirects the PC. When an instruction fetch is still outstanding at the time of the exception, it drains and discards that fetch.

## Interface
- No parameters; stage count fixed at 5.
- clk  in  1  pipeline clock
- reset  in  1  synchronous, active-high
- IF_done, ID_done, EXE_done, MEM_done, WB_done  in  1 each  stage finishes its work this cycle (e.g. memory ack, divider done)
- ID_hazard  in  1  load-use stall request from ID
- IF_busy  in  1  instruction fetch outstanding on the bus
- MEM_exc  in  5  exception flags of the MEM instruction: [4] overflow, [3] reserved instr, [2] break, [1] syscall, [0] PC fetch address error
- MEM_delay  in  1  MEM instruction sits in a delay slot
- MEM_pc  in  32  PC of MEM instruction
- IF_over, ID_over, EXE_over, MEM_over, WB_over  out  1 each
- IF_allow_in, ID_allow_in, EXE_allow_in, MEM_allow_in, WB_allow_in  out  1 each
- IF_valid, ID_valid, EXE_valid, MEM_valid, WB_valid  out  1 each
- cancel  out  1  clears IF/ID, ID/EXE, EXE/MEM, MEM/WB registers
- pc_redirect  out  1  PC loads exception vector 0xBFC0_0380 this edge
- fetch_en  out  1  IF may launch a new fetch
- drop_fetch  out  1  discard data returned for the outstanding fetch
- exc_cause  out  5  latched ExcCode
- exc_bd  out  1  latched delay-slot flag
- exc_epc  out  32  latched EPC

## Operation
- Combinational stage handshake:
  - `ID_over = ID_valid & ID_done & ~ID_hazard`.
  - Every other stage: `X_over = X_valid & X_done`, except `MEM_over` is forced 0 when `take_exc`.
  - `WB_allow_in = ~WB_valid | WB_done`.
  - For each earlier stage X with successor Y: `X_allow_in = ~X_valid | (X_over & Y_allow_in)`.
- Valid update on each edge:
  - Stage Y with predecessor X: if `Y_allow_in`, `Y_valid <= X_over`; otherwise hold.
  - IF: if `IF_allow_in`, `IF_valid <= fetch_en`.
- `take_exc = MEM_valid & (|MEM_exc) & state==RUN`.
- `cancel = pc_redirect = take_exc`, both combinational.
  - On that edge, IF..MEM valid bits clear.
  - WB is unaffected, because it holds an older instruction.
- Cause priority, lowest bit first:
  - [0] → 4 (AdEL)
  - [1] → 8 (Sys)
  - [2] → 9 (Bp)
  - [3] → 10 (RI)
  - [4] → 12 (Ov)
- On `take_exc`:
  - `exc_cause`, `exc_bd` and `exc_epc` latch.
  - `exc_epc = MEM_delay ? MEM_pc-4 : MEM_pc`, computed in 32-bit wrap-around arithmetic.
  - These outputs hold until the next `take_exc`.
- FSM:
  - RUN: `fetch_en=1`. On `take_exc`, go to DRAIN if `IF_busy`, else stay in RUN.
  - DRAIN: `fetch_en=0`, `drop_fetch=1`, `take_exc` is suppressed. Go to RUN when `IF_busy==0`.

## Timing
- Reset values:
  - All valid bits 0, state RUN.
  - `exc_cause`, `exc_bd` and `exc_epc` are 0.
  - `cancel` and `pc_redirect` are 0 while reset is high.
- Reset overrides everything, including mid-DRAIN, where it returns the FSM to RUN.
- Instruction advances one stage per cycle with zero bubbles when all `*_done` are held high.
- `cancel` is exactly one cycle wide per exception.
- The first refetch launches:
  - the cycle after `take_exc` when no fetch is in flight;
  - otherwise, the cycle after `IF_busy` falls.
- `ID_hazard` inserts exactly one bubble into EXE per stalled cycle; IF holds.
- A WB stall (`WB_done=0`) back-pressures all stages in the same cycle; there is no skid.
- `take_exc` with `MEM_done=0`: the exception is still taken, and MEM does not wait.

## Structure
- Shared package `mips_pkg`:
  - ExcCode constants (`EXC_ADEL`=4, `EXC_SYS`=8, `EXC_BP`=9, `EXC_RI`=10, `EXC_OV`=12)
  - exception vector constant
  - FSM state enum `{RUN, DRAIN}`
- Sub-module `exc_prio_enc`: combinational 5-bit flags → 5-bit ExcCode. The rest of the block is flat.

## Test plan
- Reset, then all `*_done=1` with no hazards → an instruction entering IF at cycle 1 reaches `WB_valid=1` at cycle 5; `cancel` stays 0.
- `ID_hazard=1` for 2 cycles → `EXE_valid=0` for 2 cycles; `IF_valid`/`ID_valid` held; the pipeline resumes with no lost instruction.
- `WB_done=0` for 3 cycles with a full pipe → every `*_allow_in=0`; the valid bits are unchanged after release.
- `MEM_exc=5'b00010`, `MEM_delay=1`, `MEM_pc=0x8000_0010`, `IF_busy=0` → one-cycle `cancel`/`pc_redirect`; `exc_cause=8`, `exc_bd=1`, `exc_epc=0x8000_000C`; IF..MEM valid bits 0 next cycle; `WB_valid` preserved.
- `MEM_exc=5'b10001` with `IF_busy=1` for 4 more cycles → `exc_cause=4`; `drop_fetch=1`/`fetch_en=0` for those 4 cycles; return to RUN; a second exception during DRAIN is ignored.
- `reset` asserted during DRAIN → next cycle state RUN, `fetch_en=1`, all valid bits 0, latched exception fields cleared to 0.
